// File: rtl/fft_frame_loader_pkg.sv
// fft_pkg: shared sample/frame types and constants for the FFT input loader
package fft_pkg;
  localparam int SAMPLE_W = 34;
  localparam int HALF_W = 17;
  localparam int FFT_N = 128;
  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;
  typedef enum logic {FILL, FULL} loader_state_t;
  function automatic logic [6:0] bitrev7(input logic [6:0] x);
    for (int i = 0; i < 7; i++) bitrev7[i] = x[6-i];
  endfunction
endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample stream in, held frame out, plus status
interface fft_frame_loader_if #(parameter int N = 128, parameter int SW = 34);
  logic s_valid, s_ready, s_last;
  logic [SW-1:0] s_data;
  logic frame_valid, frame_ready, err_len;
  logic [N*SW-1:0] frame_data;
  logic [15:0] frame_cnt;
  modport master(output s_valid, s_data, s_last, frame_ready,
                 input s_ready, frame_valid, frame_data, err_len, frame_cnt);
  modport slave(input s_valid, s_data, s_last, frame_ready,
                output s_ready, frame_valid, frame_data, err_len, frame_cnt);
endinterface

// File: rtl/fft_slot_decoder.sv
// fft_slot_decoder: one-hot slot write enable from wr_idx, bit-reversed when FFT_LOADER_BITREV_EN is defined
module fft_slot_decoder #(parameter int N = 128, parameter int CW = 7) (
  input  logic          en,
  input  logic [CW-1:0] wr_idx,
  output logic [N-1:0]  we
);
  logic [CW-1:0] slot;
`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    slot = '0;
    for (int i = 0; i < CW; i++) slot[i] = wr_idx[CW-1-i];
  end
`else
  assign slot = wr_idx;
`endif
  assign we = en ? N'(1) << slot : '0;
endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: assembles N serial samples into a held flat frame; FFT_LOADER_BITREV_EN selects bit-reversed slot order
module fft_frame_loader import fft_pkg::*; #(
  parameter int N = FFT_N,
  parameter int SW = SAMPLE_W,
  parameter int CW = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  fft_frame_loader_if.slave bus
);
  loader_state_t state_q, state_d;
  logic [CW-1:0] wr_idx;
  logic [N-1:0][SW-1:0] frame_q;
  logic [N-1:0] we;
  logic accept, last_slot, commit, consume;
  assign accept = bus.s_valid && bus.s_ready;
  assign last_slot = wr_idx == CW'(N-1);
  // an early s_last discards its sample; the final slot is kept with or without s_last
  assign commit = accept && (last_slot || !bus.s_last);
  assign consume = bus.frame_valid && bus.frame_ready;
  assign bus.s_ready = state_q == FILL;
  assign bus.frame_valid = state_q == FULL;
  assign bus.frame_data = frame_q;
  always_comb begin
    state_d = (commit && last_slot) ? FULL : consume ? FILL : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else state_q <= state_d;
  end
  fft_slot_decoder #(.N(N), .CW(CW)) u_dec (.en(commit), .wr_idx(wr_idx), .we(we));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      bus.err_len <= 1'b0;
      bus.frame_cnt <= '0;
      frame_q <= '0;
    end else begin
      bus.err_len <= accept && (bus.s_last != last_slot);
      if (accept) wr_idx <= commit ? wr_idx + 1'b1 : '0;
      if (consume) bus.frame_cnt <= bus.frame_cnt + 1'b1;
      for (int k = 0; k < N; k++) if (we[k]) frame_q[k] <= bus.s_data;
    end
  end
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: directed scoreboard bench for fft_frame_loader
module tb_fft_frame_loader;
  import fft_pkg::*;
  localparam int N = FFT_N;
  localparam int SW = SAMPLE_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fft_frame_loader_if #(.N(N), .SW(SW)) bus();
  fft_frame_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [SW-1:0] q[$];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int slot_of(input int i);
`ifdef FFT_LOADER_BITREV_EN
    return int'(bitrev7(7'(i)));
`else
    return i;
`endif
  endfunction
  task automatic chk_frame(input string tag);
    logic [N-1:0][SW-1:0] exp, obs;
    int bad, first;
    bad = 0;
    first = -1;
    exp = '0;
    checks++;
    assert (q.size() >= N) else begin
      errors++;
      $error("FAIL %s scoreboard holds %0d samples, expected %0d", tag, q.size(), N);
    end
    if (q.size() >= N) begin
      for (int i = 0; i < N; i++) exp[slot_of(i)] = q.pop_front();
      obs = bus.frame_data;
      for (int k = 0; k < N; k++)
        if (obs[k] !== exp[k]) begin
          bad++;
          if (first < 0) first = k;
        end
      assert (bad == 0) else begin
        errors++;
        $error("FAIL %s %0d bad slots, slot %0d observed=%0h expected=%0h", tag, bad, first, obs[first], exp[first]);
      end
    end
  endtask
  task automatic send(input logic [SW-1:0] d, input bit last, input bit gaps);
    int b;
    b = 0;
    if (gaps)
      while ($urandom_range(1) == 1) begin
        bus.s_valid = 1'b0;
        bus.s_data = SW'($urandom);
        bus.s_last = 1'($urandom_range(1));
        tick;
      end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_last = last;
    while (!bus.s_ready && b < 300) begin
      tick;
      b++;
    end
    if (b == 300) chk("s_ready_timeout", {63'b0, bus.s_ready}, 64'd1);
    q.push_back(d);
    tick;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask
  task automatic wait_frame(input string tag);
    int b;
    b = 0;
    while (!bus.frame_valid && b < 300) begin
      tick;
      b++;
    end
    chk(tag, {63'b0, bus.frame_valid}, 64'd1);
  endtask
  task automatic consume(input int cnt);
    bus.frame_ready = 1'b1;
    tick;
    bus.frame_ready = 1'b0;
    chk("consume_fv", {63'b0, bus.frame_valid}, 64'd0);
    chk("consume_s_ready", {63'b0, bus.s_ready}, 64'd1);
    chk("consume_cnt", {48'b0, bus.frame_cnt}, 64'(cnt));
  endtask
  function automatic logic [SW-1:0] cplx(input int k);
    cplx_t c;
    c.re = 17'(k * 3 + 5);
    c.im = 17'(-k);
    return c;
  endfunction
  initial begin
    logic [N*SW-1:0] held;
    int hold_bad;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (2) tick;
    chk("rst_s_ready", {63'b0, bus.s_ready}, 64'd1);
    chk("rst_fv", {63'b0, bus.frame_valid}, 64'd0);
    chk("rst_data_zero", {63'b0, bus.frame_data == '0}, 64'd1);
    chk("rst_err", {63'b0, bus.err_len}, 64'd0);
    chk("rst_cnt", {48'b0, bus.frame_cnt}, 64'd0);
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < N; k++) send(SW'(k), k == N - 1, 1'b0);
    chk("lat_fv", {63'b0, bus.frame_valid}, 64'd1);
    chk("full_s_ready", {63'b0, bus.s_ready}, 64'd0);
    chk("full_err", {63'b0, bus.err_len}, 64'd0);
`ifdef FFT_LOADER_BITREV_EN
    chk("bitrev_slot1", 64'(bus.frame_data[SW*1 +: SW]), 64'd64);
    chk("bitrev_slot127", 64'(bus.frame_data[SW*127 +: SW]), 64'd127);
`endif
    chk_frame("frame_ramp");
    held = bus.frame_data;
    hold_bad = 0;
    bus.s_valid = 1'b1;
    bus.s_data = '1;
    bus.s_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (bus.frame_data !== held || !bus.frame_valid || bus.s_ready) hold_bad++;
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    chk("hold_20", 64'(hold_bad), 64'd0);
    consume(1);
    for (int k = 0; k < 10; k++) send(cplx(k), 1'b0, 1'b0);
    bus.frame_ready = 1'b1;
    tick;
    bus.frame_ready = 1'b0;
    chk("fill_ready_ignored_cnt", {48'b0, bus.frame_cnt}, 64'd1);
    chk("fill_ready_ignored_s_ready", {63'b0, bus.s_ready}, 64'd1);
    for (int k = 10; k < N; k++) send(cplx(k), k == N - 1, 1'b0);
    chk("lat_fv2", {63'b0, bus.frame_valid}, 64'd1);
    chk_frame("frame_cplx");
    consume(2);
    for (int k = 0; k <= 50; k++) send(SW'(k + 1000), k == 50, 1'b0);
    q.delete();
    chk("early_err", {63'b0, bus.err_len}, 64'd1);
    chk("early_fv", {63'b0, bus.frame_valid}, 64'd0);
    tick;
    chk("early_err_pulse", {63'b0, bus.err_len}, 64'd0);
    for (int k = 0; k < N; k++) send(SW'({$urandom, $urandom}), k == N - 1, 1'b0);
    chk("after_early_fv", {63'b0, bus.frame_valid}, 64'd1);
    chk_frame("frame_after_early");
    consume(3);
    for (int k = 0; k < N; k++) send(SW'({$urandom, $urandom}), k == N - 1, 1'b1);
    wait_frame("gaps_fv");
    chk_frame("frame_gaps");
    consume(4);
    for (int k = 0; k < N; k++) send(SW'(k * 7 + 3), 1'b0, 1'b0);
    chk("nolast_err", {63'b0, bus.err_len}, 64'd1);
    chk("nolast_fv", {63'b0, bus.frame_valid}, 64'd1);
    chk_frame("frame_nolast");
    consume(5);
    for (int k = 0; k < 70; k++) send(SW'(k + 500), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_s_ready", {63'b0, bus.s_ready}, 64'd1);
    chk("midrst_fv", {63'b0, bus.frame_valid}, 64'd0);
    chk("midrst_data_zero", {63'b0, bus.frame_data == '0}, 64'd1);
    chk("midrst_err", {63'b0, bus.err_len}, 64'd0);
    chk("midrst_cnt", {48'b0, bus.frame_cnt}, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < N; k++) send(cplx(N - 1 - k), k == N - 1, 1'b0);
    chk("post_rst_fv", {63'b0, bus.frame_valid}, 64'd1);
    chk_frame("frame_post_rst");
    consume(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
